// File: rtl/sequencer_fetch.sv
// Program sequencer fetch stage: walks ROM addresses 0..last for N passes
// and hands instructions to the datapath over a valid/ready slot.
package affine_pkg;
  localparam int A      = 4;
  localparam int W_INST = 28;
endpackage

module sequencer_fetch #(
  parameter int A      = affine_pkg::A,
  parameter int W_INST = affine_pkg::W_INST,
  parameter int W_PASS = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [A-1:0]      last_addr_i,
  input  logic [W_PASS-1:0] passes_i,
  output logic [A-1:0]      rom_addr_o,
  input  logic [W_INST-1:0] rom_data_i,
  output logic [W_INST-1:0] inst_o,
  output logic [A-1:0]      inst_addr_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_n;

  logic [A-1:0]      pc;
  logic [A-1:0]      last_q;
  logic [W_PASS-1:0] passes_q;
  logic [W_PASS-1:0] pass_cnt;
  logic              primed;

  logic hs;
  logic slot_free;
  logic at_last;
  logic final_pass;
  logic do_start;
  logic load;
  logic clr_valid;
  logic done_n;

  assign hs         = inst_valid_o && inst_ready_i;
  assign slot_free  = !inst_valid_o || inst_ready_i;
  assign at_last    = (pc == last_q);
  assign final_pass = (pass_cnt == passes_q - W_PASS'(1));
  assign rom_addr_o = pc;
  assign busy_o     = (state != IDLE);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_n   = state;
    do_start  = 1'b0;
    load      = 1'b0;
    clr_valid = 1'b0;
    done_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          do_start = 1'b1;
          state_n  = RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          clr_valid = 1'b1;
          state_n   = IDLE;
        end else if (primed && slot_free) begin
          load = 1'b1;
          if (at_last && final_pass) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_i) begin
          clr_valid = 1'b1;
          state_n   = IDLE;
        end else if (hs) begin
          clr_valid = 1'b1;
          done_n    = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Program latch, pc/pass walk and the output slot
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc           <= '0;
      last_q       <= '0;
      passes_q     <= '0;
      pass_cnt     <= '0;
      primed       <= 1'b0;
      inst_o       <= '0;
      inst_addr_o  <= '0;
      inst_valid_o <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= done_n;
      if (do_start) begin
        last_q   <= last_addr_i;
        passes_q <= (passes_i == '0) ? W_PASS'(1) : passes_i;
        pc       <= '0;
        pass_cnt <= '0;
        primed   <= 1'b0;
      end
      // first fetch waits one settle cycle after start
      if (state == RUN) primed <= 1'b1;
      if (load) begin
        inst_o       <= rom_data_i;
        inst_addr_o  <= pc;
        inst_valid_o <= 1'b1;
        if (at_last) begin
          pc       <= '0;
          pass_cnt <= pass_cnt + W_PASS'(1);
        end else begin
          pc <= pc + A'(1);
        end
      end
      if (clr_valid) inst_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/sequencer_fetch.md
SEQUENCER_FETCH -- requirements
Module: sequencer_fetch

Interface
REQ-001 SHALL take parameter A from the affine package: ROM address width.
REQ-002 SHALL take parameter W_INST from the affine package: instruction width (28).
REQ-003 SHALL take parameter W_PASS, default 8: width of the pass counter.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk_i  input  1  clock; all state updates on its rising edge.
REQ-006 rst_i  input  1  synchronous, active-high reset.
REQ-007 start_i  input  1  start request; sampled only in IDLE.
REQ-008 abort_i  input  1  cancel the running program.
REQ-009 last_addr_i  input  A  address of the last program instruction; latched at start.
REQ-010 passes_i  input  W_PASS  number of program passes; latched at start.
REQ-011 rom_addr_o  output  A  fetch address to the instruction ROM.
REQ-012 rom_data_i  input  W_INST  combinational ROM data for rom_addr_o.
REQ-013 inst_o  output  W_INST  registered instruction to the datapath.
REQ-014 inst_addr_o  output  A  ROM address of inst_o.
REQ-015 inst_valid_o  output  1  inst_o is valid.
REQ-016 inst_ready_i  input  1  datapath accepts inst_o.
REQ-017 busy_o  output  1  high whenever state is not IDLE.
REQ-018 done_o  output  1  one-cycle completion pulse.

Function
REQ-019 SHALL have states IDLE, RUN and DRAIN; rom_addr_o SHALL equal the pc register.
REQ-020 In IDLE with start_i=1: latch last_addr_i and max(passes_i,1), pc<=0, pass_cnt<=0, go to RUN.
REQ-021 Handshake: an instruction transfers on any cycle with inst_valid_o=1 and inst_ready_i=1.
REQ-022 The output slot is free when inst_valid_o=0 or a handshake occurs in that cycle.
REQ-023 In RUN with the slot free: inst_o<=rom_data_i, inst_addr_o<=pc, inst_valid_o<=1, pc advances.
REQ-024 pc advance: pc+1, or wrap to 0 with pass_cnt+1 when pc equals the latched last address.
REQ-025 On the wrap of the final pass, SHALL go to DRAIN and issue no further loads.
REQ-026 While inst_valid_o=1 and inst_ready_i=0: inst_o, inst_addr_o, inst_valid_o and pc SHALL hold.
REQ-027 In DRAIN on handshake: inst_valid_o<=0, done_o<=1 for one cycle, go to IDLE.
REQ-028 Latency: start_i sampled at edge k SHALL give inst_valid_o=1 after edge k+2.
REQ-029 Throughput SHALL be one instruction per cycle while inst_ready_i is held high.
REQ-030 Total instructions issued SHALL be (last_addr+1) * max(passes,1), in address order per pass.
REQ-031 last_addr=0 SHALL issue address 0 once per pass.
REQ-032 last_addr=2^A-1 SHALL issue all addresses with no wrap before the last address.
REQ-033 start_i outside IDLE SHALL be ignored; input changes after latching SHALL have no effect.
REQ-034 abort_i in RUN or DRAIN: inst_valid_o<=0, go to IDLE, no done_o; abort_i has priority over a handshake.
REQ-035 abort_i in IDLE SHALL have no effect; if start_i and abort_i are both high in IDLE, start wins.

Reset
REQ-036 rst_i has priority over all inputs.
REQ-037 On rst_i: state=IDLE; pc, pass_cnt, inst_o, inst_addr_o = 0; inst_valid_o, busy_o, done_o = 0.
REQ-038 Reset mid-program SHALL discard the pending instruction with no done_o.

Verification
REQ-039 last_addr=3, passes=1, ready=1 -> addresses 0,1,2,3 on consecutive cycles; done_o one cycle after the handshake of address 3.
REQ-040 last_addr=2, passes=3 -> 9 instructions at addresses 0,1,2,0,1,2,0,1,2; passes=0 -> 3 instructions.
REQ-041 ready low 4 cycles while address 1 is valid -> inst_o/inst_addr_o stable; no loss or duplication; resumes at address 2.
REQ-042 abort_i at the third issued instruction -> inst_valid_o low next cycle, busy_o low, done_o never pulses; a new start works.
REQ-043 rst_i during RUN with last_addr=3 -> all outputs zero next cycle; start_i while busy is ignored.
REQ-044 last_addr=0, passes=2, ready toggling 1/0 -> exactly two address-0 transfers, then one done_o pulse.
